// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO family.
// Holds the default geometry and a constant-evaluable log2 used to size pointers.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 10;
  localparam int DEFAULT_DEPTH  = 8;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port storage array for the FIFO: one synchronous write port and one read
// port whose output register only updates on a read enable.
module fifo_mem_2p #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  // Array contents are deliberately left unreset so the storage maps to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register holds the last word read until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost
// thresholds, sticky overflow/underflow flags and a read-valid strobe.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic [ADDR_W:0]   ae_thresh,
  input  logic              clr_err,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              valid_reg;
  logic              overflow_reg;
  logic              underflow_reg;
  logic              push_ok;
  logic              pop_ok;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_CNT);

  // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      end
      count_reg <= count_next;
      valid_reg <= pop_ok;
    end
  end

  // A fresh error on the clearing edge wins over the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= (push & ~push_ok) | (overflow_reg & ~clr_err);
      underflow_reg <= (pop & ~pop_ok) | (underflow_reg & ~clr_err);
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_reg),
    .wr_data (data_in),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr_reg),
    .rd_data (data_out)
  );

  assign valid_out    = valid_reg;
  assign count        = count_reg;
  assign almost_full  = (count_reg >= af_thresh);
  assign almost_empty = (count_reg <= ae_thresh);
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (DATA_W=10, DEPTH=8) using a queue
// scoreboard of expected read data plus a small occupancy/flag model.
module tb_fifo_sync_param;

  localparam int DW = 10;
  localparam int DP = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_in;
  logic [AW:0]   af_thresh;
  logic [AW:0]   ae_thresh;
  logic          clr_err;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] sb[$];
  int            m_cnt;
  logic          m_ovf;
  logic          m_unf;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .data_in      (data_in),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .clr_err      (clr_err),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check_val({tag, " count"}, 32'(count), 32'(m_cnt));
    check_val({tag, " full"}, 32'(full), 32'(m_cnt == DP));
    check_val({tag, " empty"}, 32'(empty), 32'(m_cnt == 0));
    check_val({tag, " almost_full"}, 32'(almost_full), 32'(m_cnt >= int'(af_thresh)));
    check_val({tag, " almost_empty"}, 32'(almost_empty), 32'(m_cnt <= int'(ae_thresh)));
    check_val({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    check_val({tag, " underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input string tag, input logic p, input logic q,
                      input logic [DW-1:0] d, input logic c);
    logic          pop_ok;
    logic          push_ok;
    logic [DW-1:0] exp_data;
    push    = p;
    pop     = q;
    data_in = d;
    clr_err = c;
    exp_data = '0;
    pop_ok   = q && (m_cnt != 0);
    push_ok  = p && ((m_cnt != DP) || pop_ok);
    if (pop_ok) exp_data = sb.pop_front();
    if (push_ok) sb.push_back(d);
    m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
    m_ovf = (p && !push_ok) || (m_ovf && !c);
    m_unf = (q && !pop_ok) || (m_unf && !c);
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
    $display("[%0t] %s push=%0b pop=%0b din=0x%0h -> valid=%0b dout=0x%0h count=%0d ovf=%0b unf=%0b",
             $time, tag, p, q, d, valid_out, data_out, count, overflow, underflow);
    check_val({tag, " valid_out"}, 32'(valid_out), 32'(pop_ok));
    if (pop_ok) check_val({tag, " data_out"}, 32'(data_out), 32'(exp_data));
    check_status(tag);
  endtask

  initial begin
    reset     = 1'b1;
    push      = 1'b0;
    pop       = 1'b0;
    data_in   = '0;
    clr_err   = 1'b0;
    af_thresh = 4'd6;
    ae_thresh = 4'd2;
    m_cnt     = 0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;

    #12;
    check_val("por data_out", 32'(data_out), 32'h0);
    check_val("por valid_out", 32'(valid_out), 32'h0);
    check_status("por");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Boundary: af_thresh=0 forces almost_full even when empty.
    af_thresh = 4'd0;
    #1;
    check_val("af0 almost_full", 32'(almost_full), 32'h1);
    af_thresh = 4'd6;

    // 1: reset mid-burst with flags and valid set.
    step("rst-pre", 1'b0, 1'b1, 10'h0, 1'b0);
    step("rst-pre", 1'b1, 1'b0, 10'h011, 1'b0);
    step("rst-pre", 1'b1, 1'b0, 10'h022, 1'b0);
    step("rst-pre", 1'b1, 1'b1, 10'h033, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    $display("[%0t] async reset: count=%0d valid=%0b dout=0x%0h", $time, count, valid_out, data_out);
    check_val("async rst data_out", 32'(data_out), 32'h0);
    check_val("async rst valid_out", 32'(valid_out), 32'h0);
    check_status("async rst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 2: fill, then overflow.
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 1'b0, DW'(i), 1'b0);
    step("fill-ovf", 1'b1, 1'b0, 10'h09, 1'b0);
    ae_thresh = 4'd8;
    #1;
    check_val("ae8 almost_empty", 32'(almost_empty), 32'h1);
    ae_thresh = 4'd2;

    // 3: drain, then underflow.
    for (int i = 1; i <= 9; i++) step("drain", 1'b0, 1'b1, 10'h0, 1'b0);
    step("clr", 1'b0, 1'b0, 10'h0, 1'b1);

    // 4: pointer wrap.
    for (int i = 0; i < 5; i++) step("wrap-a", 1'b1, 1'b0, DW'(10'h050 + i), 1'b0);
    for (int i = 0; i < 5; i++) step("wrap-a", 1'b0, 1'b1, 10'h0, 1'b0);
    for (int i = 0; i < 8; i++) step("wrap-b", 1'b1, 1'b0, DW'(10'h100 + i), 1'b0);
    for (int i = 0; i < 8; i++) step("wrap-b", 1'b0, 1'b1, 10'h0, 1'b0);

    // 5: simultaneous push+pop when full, then when empty.
    for (int i = 0; i < 8; i++) step("sim-fill", 1'b1, 1'b0, DW'(10'h200 + i), 1'b0);
    step("sim-full", 1'b1, 1'b1, 10'h3FF, 1'b0);
    for (int i = 0; i < 8; i++) step("sim-drain", 1'b0, 1'b1, 10'h0, 1'b0);
    step("sim-empty", 1'b1, 1'b1, 10'h055, 1'b0);
    step("sim-pop", 1'b0, 1'b1, 10'h0, 1'b0);

    // 6: clear sticky flags, then clear coinciding with a rejected push.
    for (int i = 0; i < 8; i++) step("ce-fill", 1'b1, 1'b0, DW'(10'h2A0 + i), 1'b0);
    step("ce-ovf", 1'b1, 1'b0, 10'h2FF, 1'b0);
    step("ce-clr", 1'b0, 1'b0, 10'h0, 1'b1);
    step("ce-clr+push", 1'b1, 1'b0, 10'h1EE, 1'b1);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           DW'($urandom), 1'($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
